// File: rtl/vga_block_ctrl.sv
// Bouncing-block VGA pattern generator.
// Moves a BLOCK_W square inside a SIDE_W blue border and paints each pixel.
// Ports:
//   vga_clk, sys_rst         pixel clock, async active-high reset
//   frame_start, pause       per-frame update pulse, position freeze level
//   pixel_xpos, pixel_ypos   current pixel from the timing driver
//   pixel_data               registered RGB565 colour (1-cycle latency)
//   block_x, block_y         committed block top-left corner
//   dir_x, dir_y             committed direction (1 = right / down)
//   bounce_cnt               edge reversal count, wraps at 255
module vga_block_ctrl #(
  parameter int unsigned H_DISP    = 640,
  parameter int unsigned V_DISP    = 480,
  parameter int unsigned SIDE_W    = 10,
  parameter int unsigned BLOCK_W   = 40,
  parameter int unsigned STEP      = 1,
  parameter int unsigned FRAME_DIV = 1
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        frame_start,
  input  logic        pause,
  input  logic [9:0]  pixel_xpos,
  input  logic [9:0]  pixel_ypos,
  output logic [15:0] pixel_data,
  output logic [9:0]  block_x,
  output logic [9:0]  block_y,
  output logic        dir_x,
  output logic        dir_y,
  output logic [7:0]  bounce_cnt
);

  localparam int unsigned CW = 10;
  localparam int unsigned AW = 11;
  localparam int unsigned FW = 8;

  localparam logic [AW-1:0] SIDE  = AW'(SIDE_W);
  localparam logic [AW-1:0] BLK   = AW'(BLOCK_W);
  localparam logic [AW-1:0] STP   = AW'(STEP);
  localparam logic [AW-1:0] H_LIM = AW'(H_DISP);
  localparam logic [AW-1:0] V_LIM = AW'(V_DISP);
  localparam logic [AW-1:0] X_FAR = AW'(H_DISP - SIDE_W);
  localparam logic [AW-1:0] Y_FAR = AW'(V_DISP - SIDE_W);
  localparam logic [FW-1:0] DIV_LAST = FW'(FRAME_DIV - 1);

  localparam logic [15:0] COL_BORDER = 16'h001F;
  localparam logic [15:0] COL_BLOCK  = 16'h0000;
  localparam logic [15:0] COL_BG     = 16'hFFFF;
  localparam logic [15:0] COL_OFF    = 16'h0000;

  typedef enum logic [2:0] {
    ST_WAIT, ST_DIV, ST_CALC_X, ST_CALC_Y, ST_COMMIT
  } state_t;

  state_t          state, state_n;
  logic [FW-1:0]   frame_cnt, frame_cnt_n;
  logic [CW-1:0]   sh_x, sh_x_n, sh_y, sh_y_n;
  logic            sh_dx, sh_dx_n, sh_dy, sh_dy_n;
  logic [CW-1:0]   block_x_n, block_y_n;
  logic            dir_x_n, dir_y_n;
  logic [7:0]      bounce_cnt_n;
  logic [15:0]     pix_c;
  logic [CW:0]     x_step, y_step;

  // One axis update: returns {dir, pos}. Reaching the far edge reverses in
  // the same update; the near edge is clamped once the step would cross it.
  function automatic logic [CW:0] axis_next(input logic [CW-1:0] pos,
                                            input logic dir,
                                            input logic [AW-1:0] far);
    logic [AW-1:0] p;
    p = AW'(pos);
    if (dir && (p + BLK + STP >= far))
      axis_next = {1'b0, CW'(far - BLK)};
    else if (!dir && (p < SIDE + STP))
      axis_next = {1'b1, CW'(SIDE)};
    else if (dir)
      axis_next = {1'b1, CW'(p + STP)};
    else
      axis_next = {1'b0, CW'(p - STP)};
  endfunction

  // Both axes work from committed values so CALC_Y never sees CALC_X output.
  assign x_step = axis_next(block_x, dir_x, X_FAR);
  assign y_step = axis_next(block_y, dir_y, Y_FAR);

  // Next-state and datapath.
  always_comb begin
    state_n      = state;
    frame_cnt_n  = frame_cnt;
    sh_x_n       = sh_x;
    sh_y_n       = sh_y;
    sh_dx_n      = sh_dx;
    sh_dy_n      = sh_dy;
    block_x_n    = block_x;
    block_y_n    = block_y;
    dir_x_n      = dir_x;
    dir_y_n      = dir_y;
    bounce_cnt_n = bounce_cnt;
    case (state)
      ST_WAIT: begin
        if (frame_start) state_n = ST_DIV;
      end
      ST_DIV: begin
        state_n = ST_WAIT;
        // Counter saturates at DIV_LAST while paused so the first unpaused
        // frame fires the update.
        if (frame_cnt == DIV_LAST) begin
          if (!pause) begin
            frame_cnt_n = '0;
            state_n     = ST_CALC_X;
          end
        end else begin
          frame_cnt_n = frame_cnt + FW'(1);
        end
      end
      ST_CALC_X: begin
        {sh_dx_n, sh_x_n} = x_step;
        state_n = ST_CALC_Y;
      end
      ST_CALC_Y: begin
        {sh_dy_n, sh_y_n} = y_step;
        state_n = ST_COMMIT;
      end
      ST_COMMIT: begin
        block_x_n    = sh_x;
        block_y_n    = sh_y;
        dir_x_n      = sh_dx;
        dir_y_n      = sh_dy;
        bounce_cnt_n = bounce_cnt + 8'(sh_dx ^ dir_x) + 8'(sh_dy ^ dir_y);
        state_n      = ST_WAIT;
      end
      default: state_n = ST_WAIT;
    endcase
  end

  // Pixel colour from committed position only.
  always_comb begin
    logic [AW-1:0] px, py;
    px    = AW'(pixel_xpos);
    py    = AW'(pixel_ypos);
    pix_c = COL_BG;
    if (px >= H_LIM || py >= V_LIM)
      pix_c = COL_OFF;
    else if (px < SIDE || px >= X_FAR || py < SIDE || py >= Y_FAR)
      pix_c = COL_BORDER;
    else if (px >= AW'(block_x) && px < AW'(block_x) + BLK &&
             py >= AW'(block_y) && py < AW'(block_y) + BLK)
      pix_c = COL_BLOCK;
  end

  // State and output registers.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ST_WAIT;
      frame_cnt  <= '0;
      sh_x       <= CW'(SIDE_W);
      sh_y       <= CW'(SIDE_W);
      sh_dx      <= 1'b1;
      sh_dy      <= 1'b1;
      block_x    <= CW'(SIDE_W);
      block_y    <= CW'(SIDE_W);
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      bounce_cnt <= '0;
      pixel_data <= COL_OFF;
    end else begin
      state      <= state_n;
      frame_cnt  <= frame_cnt_n;
      sh_x       <= sh_x_n;
      sh_y       <= sh_y_n;
      sh_dx      <= sh_dx_n;
      sh_dy      <= sh_dy_n;
      block_x    <= block_x_n;
      block_y    <= block_y_n;
      dir_x      <= dir_x_n;
      dir_y      <= dir_y_n;
      bounce_cnt <= bounce_cnt_n;
      pixel_data <= pix_c;
    end
  end

endmodule

// File: tb/tb_vga_block_ctrl.sv
// Self-checking bench for vga_block_ctrl: default instance (a) and a square
// 200x200, FRAME_DIV=3 instance (b), both against a frame-level model.
module tb_vga_block_ctrl;

  localparam int SIDE = 10;
  localparam int BW   = 40;
  localparam int STP  = 1;

  typedef struct {
    int x; int y; int dx; int dy; int bc; int cnt;
  } mdl_t;

  logic        clk;
  logic        rst_a, rst_b, fs_a, fs_b, pz_a, pz_b;
  logic [9:0]  px, py;
  logic [15:0] pd_a, pd_b;
  logic [9:0]  bx_a, by_a, bx_b, by_b;
  logic        dx_a, dy_a, dx_b, dy_b;
  logic [7:0]  bc_a, bc_b;

  int   errors = 0;
  int   checks = 0;
  mdl_t m_a, m_b;
  logic [15:0] prev_a, prev_b;

  vga_block_ctrl dut_a (
    .vga_clk(clk), .sys_rst(rst_a), .frame_start(fs_a), .pause(pz_a),
    .pixel_xpos(px), .pixel_ypos(py), .pixel_data(pd_a),
    .block_x(bx_a), .block_y(by_a), .dir_x(dx_a), .dir_y(dy_a),
    .bounce_cnt(bc_a));

  vga_block_ctrl #(.H_DISP(200), .V_DISP(200), .FRAME_DIV(3)) dut_b (
    .vga_clk(clk), .sys_rst(rst_b), .frame_start(fs_b), .pause(pz_b),
    .pixel_xpos(px), .pixel_ypos(py), .pixel_data(pd_b),
    .block_x(bx_b), .block_y(by_b), .dir_x(dx_b), .dir_y(dy_b),
    .bounce_cnt(bc_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m = '{x: SIDE, y: SIDE, dx: 1, dy: 1, bc: 0, cnt: 0};
    return m;
  endfunction

  function automatic void axis(input int p, input int d, input int full,
                               output int np, output int nd);
    int far;
    far = full - SIDE;
    if (d == 1 && p + BW + STP >= far) begin
      np = far - BW; nd = 0;
    end else if (d == 0 && p < SIDE + STP) begin
      np = SIDE; nd = 1;
    end else begin
      np = (d == 1) ? p + STP : p - STP; nd = d;
    end
  endfunction

  function automatic mdl_t mdl_frame(input mdl_t m, input bit pz,
                                     input int h, input int v, input int fd);
    mdl_t r;
    int nd;
    r = m;
    if (m.cnt == fd - 1) begin
      if (!pz) begin
        r.cnt = 0;
        axis(m.x, m.dx, h, r.x, nd);
        if (nd != m.dx) r.bc = (r.bc + 1) % 256;
        r.dx = nd;
        axis(m.y, m.dy, v, r.y, nd);
        if (nd != m.dy) r.bc = (r.bc + 1) % 256;
        r.dy = nd;
      end
    end else begin
      r.cnt = m.cnt + 1;
    end
    return r;
  endfunction

  function automatic logic [15:0] pix_model(input int x, input int y,
                                            input int bx, input int by,
                                            input int h, input int v);
    if (x >= h || y >= v) return 16'h0000;
    if (x < SIDE || x >= h - SIDE || y < SIDE || y >= v - SIDE) return 16'h001F;
    if (x >= bx && x < bx + BW && y >= by && y < by + BW) return 16'h0000;
    return 16'hFFFF;
  endfunction

  task automatic check_state(input string tag, input bit sel, input mdl_t e);
    logic [9:0] ox, oy;
    logic       odx, ody;
    logic [7:0] obc;
    ox  = sel ? bx_b : bx_a;
    oy  = sel ? by_b : by_a;
    odx = sel ? dx_b : dx_a;
    ody = sel ? dy_b : dy_a;
    obc = sel ? bc_b : bc_a;
    checks++;
    assert (ox === 10'(e.x)) else begin
      errors++; $error("FAIL %s/%0d block_x: got %0d expected %0d", tag, sel, ox, e.x);
    end
    checks++;
    assert (oy === 10'(e.y)) else begin
      errors++; $error("FAIL %s/%0d block_y: got %0d expected %0d", tag, sel, oy, e.y);
    end
    checks++;
    assert (odx === 1'(e.dx)) else begin
      errors++; $error("FAIL %s/%0d dir_x: got %0d expected %0d", tag, sel, odx, e.dx);
    end
    checks++;
    assert (ody === 1'(e.dy)) else begin
      errors++; $error("FAIL %s/%0d dir_y: got %0d expected %0d", tag, sel, ody, e.dy);
    end
    checks++;
    assert (obc === 8'(e.bc)) else begin
      errors++; $error("FAIL %s/%0d bounce_cnt: got %0d expected %0d", tag, sel, obc, e.bc);
    end
  endtask

  task automatic set_fs(input bit sel, input logic v);
    if (sel) fs_b = v; else fs_a = v;
  endtask

  // One frame_start pulse; checks outputs hold through COMMIT and update
  // exactly 4 edges after the sampling edge. 'extra' adds a pulse while busy.
  task automatic do_frame(input bit sel, input bit pz, input bit extra, input int gap);
    mdl_t old_m, new_m;
    int   fd;
    bit   fires;
    fd    = sel ? 3 : 1;
    old_m = sel ? m_b : m_a;
    new_m = sel ? mdl_frame(old_m, pz, 200, 200, 3) : mdl_frame(old_m, pz, 640, 480, 1);
    fires = (old_m.cnt == fd - 1) && !pz;
    @(negedge clk);
    if (sel) pz_b = pz; else pz_a = pz;
    set_fs(sel, 1'b1);
    @(posedge clk); #1;
    set_fs(sel, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1 && extra && fires) set_fs(sel, 1'b1);
      if (k == 2) set_fs(sel, 1'b0);
      if (k == 3) check_state("hold", sel, old_m);
      if (k == 4) check_state("update", sel, new_m);
    end
    if (sel) m_b = new_m; else m_a = new_m;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Must be entered just after a rising edge.
  task automatic pix_step(input int x, input int y);
    logic [15:0] ea, eb;
    ea = pix_model(x, y, m_a.x, m_a.y, 640, 480);
    eb = pix_model(x, y, m_b.x, m_b.y, 200, 200);
    px = 10'(x); py = 10'(y);
    #1;
    checks++;
    assert (pd_a === prev_a) else begin
      errors++; $error("FAIL pix_latency_a (%0d,%0d): got %h expected %h", x, y, pd_a, prev_a);
    end
    @(posedge clk); #1;
    checks++;
    assert (pd_a === ea) else begin
      errors++; $error("FAIL pix_a (%0d,%0d): got %h expected %h", x, y, pd_a, ea);
    end
    checks++;
    assert (pd_b === eb) else begin
      errors++; $error("FAIL pix_b (%0d,%0d): got %h expected %h", x, y, pd_b, eb);
    end
    prev_a = ea; prev_b = eb;
  endtask

  initial begin
    bit   found;
    int   bc0;
    mdl_t rm;
    rst_a = 1'b1; rst_b = 1'b1;
    fs_a = 1'b0; fs_b = 1'b0; pz_a = 1'b0; pz_b = 1'b0;
    px = '0; py = '0;
    m_a = mdl_reset(); m_b = mdl_reset();
    rm  = mdl_reset();

    #7;
    check_state("reset", 1'b0, rm);
    check_state("reset", 1'b1, rm);
    checks++;
    assert (pd_a === 16'h0000) else begin
      errors++; $error("FAIL reset_pix: got %h expected 0000", pd_a);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_a = 1'b0; rst_b = 1'b0;

    // First update from reset.
    do_frame(1'b0, 1'b0, 1'b0, 2);
    checks++;
    assert (bx_a === 10'd11 && by_a === 10'd11 && bc_a === 8'd0) else begin
      errors++; $error("FAIL first_move: got (%0d,%0d,%0d) expected (11,11,0)", bx_a, by_a, bc_a);
    end

    // Held over 5 paused frames with FRAME_DIV=3, moves on first unpaused.
    for (int i = 0; i < 5; i++) do_frame(1'b1, 1'b1, 1'b0, 1);
    checks++;
    assert (bx_b === 10'd10 && by_b === 10'd10) else begin
      errors++; $error("FAIL pause_hold: got (%0d,%0d) expected (10,10)", bx_b, by_b);
    end
    do_frame(1'b1, 1'b0, 1'b0, 1);
    checks++;
    assert (bx_b === 10'd11 && by_b === 10'd11) else begin
      errors++; $error("FAIL pause_release: got (%0d,%0d) expected (11,11)", bx_b, by_b);
    end

    // Random run on instance a until it sits at x=589 heading right.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (m_a.x == 589 && m_a.dx == 1) found = 1'b1;
      else do_frame(1'b0, $urandom_range(0, 3) == 0, 1'(($urandom_range(0, 1))),
                    $urandom_range(0, 3));
    end
    checks++;
    assert (found) else begin
      errors++; $error("FAIL reach_589: got x=%0d expected 589", bx_a);
    end
    bc0 = m_a.bc;
    do_frame(1'b0, 1'b0, 1'b0, 1);
    checks++;
    assert (bx_a === 10'd590 && dx_a === 1'b0 && bc_a === 8'(bc0 + 1)) else begin
      errors++; $error("FAIL right_edge: got (%0d,%0d,%0d) expected (590,0,%0d)", bx_a, dx_a, bc_a, bc0 + 1);
    end
    do_frame(1'b0, 1'b0, 1'b0, 1);
    checks++;
    assert (bx_a === 10'd589) else begin
      errors++; $error("FAIL right_return: got %0d expected 589", bx_a);
    end

    // Pixel sweep.
    @(posedge clk); #1;
    prev_a = pix_model(int'(px), int'(py), m_a.x, m_a.y, 640, 480);
    prev_b = pix_model(int'(px), int'(py), m_b.x, m_b.y, 200, 200);
    pix_step(5, 200);
    checks++;
    assert (pd_a === 16'h001F) else begin
      errors++; $error("FAIL pix_border_5_200: got %h expected 001F", pd_a);
    end
    pix_step(700, 10);
    checks++;
    assert (pd_a === 16'h0000) else begin
      errors++; $error("FAIL pix_off_700_10: got %h expected 0000", pd_a);
    end
    pix_step(120, 70);   pix_step(300, 300);
    pix_step(m_a.x, m_a.y);            pix_step(m_a.x - 1, m_a.y);
    pix_step(m_a.x + 39, m_a.y + 39);  pix_step(m_a.x + 40, m_a.y + 39);
    pix_step(m_a.x + 20, m_a.y + 40);  pix_step(m_a.x + 20, m_a.y - 1);
    pix_step(9, 100);    pix_step(10, 100);  pix_step(629, 100); pix_step(630, 100);
    pix_step(100, 9);    pix_step(100, 469); pix_step(100, 470); pix_step(639, 479);
    pix_step(640, 0);    pix_step(0, 480);   pix_step(1023, 1023);
    pix_step(m_b.x, m_b.y); pix_step(m_b.x + 39, m_b.y + 39); pix_step(190, 100);
    for (int i = 0; i < 30; i++) pix_step($urandom_range(0, 700), $urandom_range(0, 520));

    // Random run on instance b until at the top-left corner heading up-left.
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (m_b.x == 10 && m_b.dx == 0 && m_b.y == 10 && m_b.dy == 0 && m_b.cnt == 2)
        found = 1'b1;
      else do_frame(1'b1, $urandom_range(0, 3) == 0, 1'(($urandom_range(0, 1))),
                    $urandom_range(0, 2));
    end
    checks++;
    assert (found) else begin
      errors++; $error("FAIL reach_corner: got (%0d,%0d) expected (10,10)", bx_b, by_b);
    end
    bc0 = m_b.bc;
    do_frame(1'b1, 1'b0, 1'b0, 1);
    checks++;
    assert (bx_b === 10'd10 && by_b === 10'd10 && dx_b === 1'b1 && dy_b === 1'b1 &&
            bc_b === 8'(bc0 + 2)) else begin
      errors++; $error("FAIL corner: got (%0d,%0d,%0d,%0d,%0d) expected (10,10,1,1,%0d)",
                       bx_b, by_b, dx_b, dy_b, bc_b, bc0 + 2);
    end

    // Reset two cycles after frame_start discards the update.
    @(negedge clk); pz_a = 1'b0; fs_a = 1'b1;
    @(posedge clk); #1; fs_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst_a = 1'b1;
    #1;
    m_a = mdl_reset();
    check_state("mid_reset", 1'b0, m_a);
    checks++;
    assert (pd_a === 16'h0000) else begin
      errors++; $error("FAIL mid_reset_pix: got %h expected 0000", pd_a);
    end
    @(posedge clk); @(posedge clk); #1; rst_a = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check_state("no_commit", 1'b0, m_a);
    do_frame(1'b0, 1'b0, 1'b0, 1);
    checks++;
    assert (bx_a === 10'd11 && by_a === 10'd11) else begin
      errors++; $error("FAIL after_reset: got (%0d,%0d) expected (11,11)", bx_a, by_a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
